// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl
//   Sequences an external Sobel filter over one frame at a time. Pixels are
//   accepted on a valid/ready stream and each accepted pixel drives a single
//   filter enable. The first DISCARD filter results of a frame are dropped
//   because the line delays are still filling. At frame end the controller
//   pushes DISCARD zero pixels to flush the delays. Border pixels are forced
//   to 0. Results are queued in a small output FIFO. Enables are only issued
//   while the FIFO has room for every kept result still in flight, so
//   downstream backpressure never loses a sample.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, begins a frame when idle
//   s_data/s_valid/
//   s_ready             input pixel stream (pixel value in [7:0])
//   filt_en/filt_din    filter enable and filter stream_input
//   filt_dout           filter stream_output, valid FILT_LAT edges after filt_en
//   m_data/m_valid/
//   m_ready/m_last      output gradient stream, m_last on the final pixel
//   busy                frame in progress
//   frame_done          one-cycle pulse after the m_last handshake
module sobel_stream_ctrl #(
  parameter int PIX_PER_LINE = 695,
  parameter int LINES        = 512,
  parameter int FILT_LAT     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              filt_en,
  output logic [DATA_W-1:0] filt_din,
  input  logic [DATA_W-1:0] filt_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int TOTAL   = PIX_PER_LINE * LINES;
  localparam int DISCARD = PIX_PER_LINE + 2;
  localparam int EN_W    = $clog2(TOTAL + DISCARD + 1);
  localparam int OUT_W   = $clog2(TOTAL + 1);
  localparam int COL_W   = $clog2(PIX_PER_LINE + 1);
  localparam int ROW_W   = $clog2(LINES + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SUM_W   = $clog2(FIFO_DEPTH + FILT_LAT + 1);

  localparam logic [EN_W-1:0]  EN_TOTAL   = EN_W'(TOTAL);
  localparam logic [EN_W-1:0]  EN_DISCARD = EN_W'(DISCARD);
  localparam logic [EN_W-1:0]  EN_END     = EN_W'(TOTAL + DISCARD);
  localparam logic [OUT_W-1:0] OUT_LAST   = OUT_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(PIX_PER_LINE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(LINES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0] SUM_DEPTH  = SUM_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [EN_W-1:0]      en_cnt_q, en_cnt_d;
  logic [OUT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 frame_done_q, frame_done_d;
  logic [FILT_LAT-1:0]  vld_p_q, vld_p_d, keep_p_q, keep_p_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [DATA_W-1:0]    mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [SUM_W-1:0]     inflight;
  logic                 credit_ok, push, pop;

  function automatic logic [DATA_W-1:0] border_mask(
    input logic [DATA_W-1:0] d,
    input logic [ROW_W-1:0]  r,
    input logic [COL_W-1:0]  c
  );
    if (r == '0 || r == ROW_LAST || c == '0 || c == COL_LAST) return '0;
    return d;
  endfunction

  // Credit: FIFO occupancy plus kept results still inside the filter
  always_comb begin
    inflight = '0;
    for (int i = 0; i < FILT_LAT; i++) begin
      inflight = inflight + SUM_W'(vld_p_q[i] & keep_p_q[i]);
    end
    credit_ok = (SUM_W'(fifo_cnt_q) + inflight) < SUM_DEPTH;
  end

  // Control FSM, enable generation, output and raster counters
  always_comb begin
    state_d      = state_q;
    en_cnt_d     = en_cnt_q;
    out_cnt_d    = out_cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    s_ready      = 1'b0;
    filt_en      = 1'b0;
    filt_din     = '0;

    if (pop) out_cnt_d = out_cnt_q + OUT_W'(1);

    if (push) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          en_cnt_d  = '0;
          out_cnt_d = '0;
          row_d     = '0;
          col_d     = '0;
        end
      end
      RUN: begin
        s_ready = credit_ok && (en_cnt_q < EN_TOTAL);
        if (s_valid && s_ready) begin
          filt_en  = 1'b1;
          filt_din = s_data;
          en_cnt_d = en_cnt_q + EN_W'(1);
          if (en_cnt_d == EN_TOTAL) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (credit_ok) begin
          filt_en  = 1'b1;
          en_cnt_d = en_cnt_q + EN_W'(1);
          if (en_cnt_d == EN_END) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_cnt_q == OUT_LAST) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tracker stage p0 captures the enable; stage p(FILT_LAT-1) lines up with filt_dout
  always_comb begin
    vld_p_d     = vld_p_q;
    keep_p_d    = keep_p_q;
    vld_p_d[0]  = filt_en;
    keep_p_d[0] = filt_en && (en_cnt_q >= EN_DISCARD);
    for (int i = 1; i < FILT_LAT; i++) begin
      vld_p_d[i]  = vld_p_q[i-1];
      keep_p_d[i] = keep_p_q[i-1];
    end
  end

  assign push = vld_p_q[FILT_LAT-1] & keep_p_q[FILT_LAT-1];

  // Output FIFO, first-word fall-through
  assign m_valid = (fifo_cnt_q != '0);
  assign m_data  = m_valid ? mem_data[rd_ptr_q] : '0;
  assign m_last  = m_valid & mem_last[rd_ptr_q];
  assign pop     = m_valid & m_ready;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= border_mask(filt_dout, row_q, col_q);
      mem_last[wr_ptr_q] <= (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      en_cnt_q     <= '0;
      out_cnt_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      vld_p_q      <= '0;
      keep_p_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      en_cnt_q     <= en_cnt_d;
      out_cnt_q    <= out_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      vld_p_q      <= vld_p_d;
      keep_p_q     <= keep_p_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_cnt_q == CNT_FULL));

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed testbench for sobel_stream_ctrl on a 4x4 image with a behavioural
// two-stage Sobel filter (|Gx|+|Gy|) attached to the filter ports.
module tb_sobel_stream_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready, filt_en, m_valid, m_ready, m_last, busy, frame_done;
  logic [31:0] s_data, filt_din, filt_dout, m_data;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sobel_stream_ctrl #(
    .PIX_PER_LINE(W),
    .LINES       (H),
    .FILT_LAT    (2),
    .FIFO_DEPTH  (4),
    .DATA_W      (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .filt_en   (filt_en),
    .filt_din  (filt_din),
    .filt_dout (filt_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Filter model: line-delay shift register, sr[0] is the newest pixel.
  // Stage 0 evaluates the window before the new pixel shifts in, so the
  // result of enable e is centred on pixel e-(W+2); stage 1 is free-running.
  logic [31:0] sr [0:2*W+2];
  logic [31:0] flt_p0, flt_p1;

  function automatic logic [31:0] sobel_win();
    int gx, gy;
    gx = (int'(sr[0]) + 2*int'(sr[W]) + int'(sr[2*W]))
       - (int'(sr[2]) + 2*int'(sr[W+2]) + int'(sr[2*W+2]));
    gy = (int'(sr[0]) + 2*int'(sr[1]) + int'(sr[2]))
       - (int'(sr[2*W]) + 2*int'(sr[2*W+1]) + int'(sr[2*W+2]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return 32'(gx + gy);
  endfunction

  always @(posedge clk) begin
    if (filt_en) begin
      flt_p0 <= sobel_win();
      for (int i = 2*W+2; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= filt_din;
    end
    flt_p1 <= flt_p0;
  end
  assign filt_dout = flt_p1;

  // Patterns: 0 constant 50, 1 left half 0 / right half 100, 2 pixel = row*10
  function automatic logic [31:0] pix(input int pat, input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    case (pat)
      0:       return 32'd50;
      1:       return (c < W/2) ? 32'd0 : 32'd100;
      default: return 32'(r * 10);
    endcase
  endfunction

  // Hand-derived results: interior 0 (constant), 400 (vertical edge), 80 (ramp)
  function automatic logic [31:0] exp_pix(input int pat, input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 32'd0;
    case (pat)
      0:       return 32'd0;
      1:       return 32'd400;
      default: return 32'd80;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".s_ready"},    32'(s_ready),    0);
    check({tag, ".filt_en"},    32'(filt_en),    0);
    check({tag, ".filt_din"},   filt_din,        0);
    check({tag, ".m_valid"},    32'(m_valid),    0);
    check({tag, ".m_last"},     32'(m_last),     0);
    check({tag, ".m_data"},     m_data,          0);
    check({tag, ".busy"},       32'(busy),       0);
    check({tag, ".frame_done"}, 32'(frame_done), 0);
  endtask

  // Runs one frame from the current negedge. vmode/rmode 0 = always high,
  // 1 = random 50%. Optional 20-cycle m_ready stall, start pulse mid-RUN,
  // abort early in FLUSH, and s_ready bubble check.
  task automatic run_frame(input int pat, input int vmode, input int rmode, input bit stall,
                           input bit start_mid, input bit abort_flush, input bit no_bubble);
    int in_idx = 0, out_idx = 0, cyc = 0, en_seen = 0;
    int stall_left = 0, stall_acc = 0, bubbles = 0, flush_cyc = 0;
    bit stall_done = 0, start_done = 0, hold = 0, hs_in, hs_out;
    logic [31:0] held = '0;

    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (out_idx < N && cyc < 2000) begin
      s_valid = (in_idx < N) && (vmode == 0 || $urandom_range(0, 1) == 1);
      s_data  = pix(pat, in_idx);
      if (stall && !stall_done && in_idx == 10) begin
        stall_done = 1;
        stall_left = 20;
      end
      m_ready = (stall_left > 0) ? 1'b0 : (rmode == 0 || $urandom_range(0, 1) == 1);
      start   = start_mid && !start_done && in_idx == 5;
      if (start) start_done = 1;
      #1;
      hs_in  = s_valid && s_ready;
      hs_out = m_valid && m_ready;
      if (filt_en) en_seen++;
      if (hs_in) check("filt_en_on_accept", 32'(filt_en), 1);
      if (filt_en) check("filt_din", filt_din, hs_in ? s_data : 32'd0);
      if (hold) check("m_data_held", m_data, held);
      hold = m_valid && !m_ready;
      held = m_data;
      if (hs_out) begin
        check("m_data", m_data, exp_pix(pat, out_idx));
        check("m_last", 32'(m_last), (out_idx == N-1) ? 1 : 0);
      end
      if (stall_left > 0) begin
        stall_left--;
        if (hs_in) stall_acc++;
      end
      if (no_bubble && in_idx < N && !s_ready) bubbles++;
      if (in_idx == N) flush_cyc++;
      @(posedge clk);
      start = 1'b0;
      if (hs_in) in_idx++;
      if (hs_out) out_idx++;
      cyc++;
      @(negedge clk);
      if (abort_flush && flush_cyc == 2) break;
    end

    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    if (abort_flush) begin
      check("flush_reached", 32'(flush_cyc), 2);
      check("busy_in_flush", 32'(busy), 1);
      check("s_ready_in_flush", 32'(s_ready), 0);
    end else begin
      check("outputs_in_budget", 32'(out_idx), N);
      check("filt_en_count", 32'(en_seen), N + W + 2);
      check("frame_done_pulse", 32'(frame_done), 1);
      if (stall) begin
        check("stall_seen", 32'(stall_done), 1);
        check("stall_accept_bound", 32'(stall_acc <= 2), 1);
      end
      if (no_bubble) check("s_ready_bubbles", 32'(bubbles), 0);
      @(negedge clk);
      #1;
      check("frame_done_clear", 32'(frame_done), 0);
      check("busy_after_frame", 32'(busy), 0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Constant image: all outputs 0, m_last only on the last
    run_frame(0, 0, 0, 0, 0, 0, 0);

    // Vertical edge: interior 400, no input bubbles
    run_frame(1, 0, 0, 0, 0, 0, 1);

    // Same image with a 20-cycle downstream stall
    run_frame(1, 0, 0, 1, 0, 0, 0);

    // Three back-to-back random-handshake frames, start pulsed mid-RUN
    run_frame(2, 1, 1, 0, 1, 0, 0);
    run_frame(1, 1, 1, 0, 1, 0, 0);
    run_frame(0, 1, 1, 0, 1, 0, 0);

    // Reset during FLUSH, then a clean frame
    run_frame(2, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid_flush");
    @(negedge clk);
    run_frame(2, 0, 0, 0, 0, 0, 0);

    // start coincident with rst: rst wins
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check("rst_start.busy", 32'(busy), 0);
    check("rst_start.s_ready", 32'(s_ready), 0);
    @(negedge clk);
    #1;
    check("rst_start.busy_later", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sobel_stream_ctrl.md
Name: sobel_stream_ctrl

Overview:
- Stream controller that sequences the Sobel filter datapath (3x3 window over line-delay registers, stream_input -> stream_output, enable-gated) for one frame at a time.
- Accepts pixels over a valid/ready handshake and pulses the filter enable once per accepted pixel.
- Discards pipeline-fill outputs, flushes the line delays with zero pixels at frame end, and masks border pixels to 0.
- Buffers results in a small credit-checked output FIFO so that downstream backpressure never drops a sample.

Parameters:
- PIX_PER_LINE, 695: image width in pixels; must equal the filter's line length.
- LINES, 512: image height in lines.
- FILT_LAT, 2: clock edges from a filter-enable cycle to the corresponding valid result on filt_dout.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least FILT_LAT+1.
- DISCARD, PIX_PER_LINE+2 (localparam): filter results dropped at frame start, and zero pixels pushed at frame end.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame when state is IDLE
- s_data  in  32  input pixel, unsigned value in [7:0], upper bits zero
- s_valid  in  1  input valid
- s_ready  out  1  input ready
- filt_en  out  1  filter enable
- filt_din  out  32  filter stream_input
- filt_dout  in  32  filter stream_output
- m_data  out  32  gradient magnitude, 0 on border pixels
- m_valid  out  1  output valid
- m_ready  in  1  output ready
- m_last  out  1  high with the final pixel of the frame
- busy  out  1  state not IDLE
- frame_done  out  1  one-cycle pulse after m_last handshake

Behaviour:
- Reset values: s_ready=0, filt_en=0, filt_din=0, m_valid=0, m_last=0, m_data=0, busy=0, frame_done=0. The FIFO, in-flight tracker, and all counters are cleared.
- Reset mid-frame aborts the frame. Partial output is lost and the filter's delay contents are don't-care.
- State IDLE:
  - s_ready=0.
  - start moves to RUN and clears in_cnt, out_cnt, and the row/col counters.
  - start in any other state is ignored.
- State RUN:
  - s_ready = credit_ok AND in_cnt < PIX_PER_LINE*LINES.
  - credit_ok = fifo_count + inflight_kept < FIFO_DEPTH, where inflight_kept is the number of tracked enables that will be pushed to the FIFO.
  - On an input handshake: filt_en=1 and filt_din=s_data in the same cycle (combinational), and in_cnt increments.
  - When in_cnt reaches PIX_PER_LINE*LINES, move to FLUSH.
- State FLUSH:
  - filt_en=1 with filt_din=0 on every cycle that credit_ok holds, until DISCARD zeros have been pushed. Then move to DRAIN.
  - s_ready=0.
- State DRAIN: wait until out_cnt = PIX_PER_LINE*LINES and the final output handshake completes. Then pulse frame_done and move to IDLE.
- In-flight tracker:
  - FILT_LAT-stage shift register recording filt_en plus a keep flag.
  - keep = 0 for the first DISCARD enables of the frame, 1 otherwise.
  - When a kept entry exits the tracker, filt_dout is sampled that cycle and pushed to the FIFO.
  - The credit rule guarantees the push never finds the FIFO full. Full-at-push is an assertion failure.
- Border mask:
  - Row/col counters follow kept pushes (raster order, col wraps at PIX_PER_LINE-1, row increments on wrap).
  - Data pushed to the FIFO is forced to 0 when row==0, row==LINES-1, col==0, or col==PIX_PER_LINE-1.
  - The m_last flag is stored per entry: set when row==LINES-1 and col==PIX_PER_LINE-1.
- Output:
  - m_valid = FIFO not empty; m_data and m_last come from the FIFO head, first-word fall-through.
  - Pop on m_valid AND m_ready.
  - Simultaneous push and pop in one cycle is allowed; fifo_count stays the same.
  - m_data is held stable while m_valid=1 and m_ready=0.
- Counts per frame: exactly PIX_PER_LINE*LINES outputs and PIX_PER_LINE*LINES+DISCARD filter enables.
- Throughput: 1 pixel/cycle sustained when m_ready is held high.
- Latency: the first output appears FILT_LAT cycles after the (DISCARD+1)-th enable.

Test Plan:
- PIX_PER_LINE=4, LINES=4, constant input 50, m_ready=1 -> 16 outputs, all 0; m_last only on the 16th; 22 filt_en pulses; frame_done one cycle after the last handshake.
- Same size, left half of each row 0 and right half 100, m_ready=1 -> interior pixels (rows 1-2, cols 1-2) = 400; border = 0; no bubbles on s_ready after the first cycle.
- m_ready=0 for 20 cycles mid-frame -> s_ready drops within FIFO_DEPTH-FILT_LAT accepted pixels; FIFO never overflows; output sequence identical to the unstalled run.
- Random s_valid/m_ready toggling at 50% over 3 back-to-back frames -> each frame yields 16 correct outputs; start asserted during RUN is ignored.
- rst asserted for 1 cycle mid-FLUSH -> next cycle all outputs at reset values and state IDLE; a following start produces a correct full frame once the first DISCARD results are discarded.
- start asserted on the same cycle as rst -> rst wins; state stays IDLE.
